// File: rtl/risa_kernel_ctrl_pkg.sv
// Shared types for the kernel command sequencer:
// command bytes, FSM states and status word layout.
package risa_kernel_ctrl_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_HALT  = 8'h02;
  localparam logic [7:0] CMD_ABORT = 8'h03;
  localparam logic [7:0] CMD_SNAP  = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BOOT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_HALTING = 3'd3,
    ST_DONE    = 3'd4
  } kctrl_state_e;

  localparam int STATUS_IDX_CTRL     = 0;
  localparam int STATUS_IDX_CMD      = 1;
  localparam int STATUS_IDX_SCYC_LO  = 2;
  localparam int STATUS_IDX_SCYC_HI  = 3;
  localparam int STATUS_IDX_SRUN_LO  = 4;
  localparam int STATUS_IDX_SRUN_HI  = 5;
  localparam int STATUS_IDX_BOOT     = 6;
  localparam int STATUS_IDX_ERR      = 7;
  localparam int STATUS_IDX_LCYC_LO  = 8;
  localparam int STATUS_IDX_LCYC_HI  = 9;
  localparam int STATUS_IDX_LRUN_LO  = 10;
  localparam int STATUS_IDX_LRUN_HI  = 11;

  typedef struct packed {
    logic [23:0]  rsvd_hi;
    logic         timeout;
    logic         illegal;
    logic [2:0]   rsvd_lo;
    kctrl_state_e state;
  } kctrl_status_t;

endpackage

// File: rtl/risa_kernel_ctrl_if.sv
// Host-side command/status bundle between the
// AXI-lite register block and the kernel sequencer.
interface risa_kernel_ctrl_if #(
  parameter int ARG_NUM = 16,
  parameter int WORD_W  = 32
);
  logic [7:0]                kernel_command;
  logic                      kernel_command_new;
  logic [ARG_NUM*WORD_W-1:0] kernel_engine_arg;
  logic                      counter_reset;
  logic                      counter_start;
  logic [ARG_NUM*WORD_W-1:0] kernel_engine_status;

  modport master (
    output kernel_command,
    output kernel_command_new,
    output kernel_engine_arg,
    output counter_reset,
    output counter_start,
    input  kernel_engine_status
  );

  modport slave (
    input  kernel_command,
    input  kernel_command_new,
    input  kernel_engine_arg,
    input  counter_reset,
    input  counter_start,
    output kernel_engine_status
  );
endinterface

// File: rtl/risa_kernel_ctrl_counter.sv
// 64-bit cycle counter: clear has priority over
// enable, wraps to zero.
module risa_cycle_counter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  output logic [63:0] cnt
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 64'd1;
    end
  end
endmodule

// File: rtl/risa_kernel_ctrl.sv
// Kernel command sequencer: core reset/boot/halt
// FSM, cycle counters and status readback.
module risa_kernel_ctrl
  import risa_kernel_ctrl_pkg::*;
#(
  parameter int ARG_NUM      = 16,
  parameter int WORD_W       = 32,
  parameter int RST_HOLD     = 16,
  parameter int HALT_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  risa_kernel_ctrl_if.slave   bus,
  input  logic                core_halt_ack_i,
  output logic                core_rst_no,
  output logic                core_halt_req_o,
  output logic [63:0]         core_boot_addr_o
);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  localparam int SW = ARG_NUM * WORD_W;

  typedef struct packed {
    kctrl_state_e  state;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   boot_addr;
    logic [7:0]    last_cmd;
    logic [15:0]   cmd_cnt;
    logic [31:0]   err_cnt;
    logic          timeout;
    logic          illegal;
    logic          rst_n;
    logic          halt_req;
    logic [63:0]   snap_cyc;
    logic [63:0]   snap_run;
  } regs_t;

  regs_t         r, r_d;
  logic [SW-1:0] status_q, status_d;
  logic [63:0]   cyc_cnt, run_cnt;
  logic          run_clr;
  logic          new_cmd;
  logic [7:0]    cmd;
  logic          acc_run, acc_halt;
  logic          acc_abort, acc_snap, bad;
  kctrl_status_t st0;
  logic          unused_arg;

  assign unused_arg = ^{bus.kernel_engine_arg[SW-1:2*WORD_W],
                        bus.kernel_engine_arg[WORD_W-1:0]};

  risa_cycle_counter u_cyc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.counter_reset),
    .en   (bus.counter_start),
    .cnt  (cyc_cnt)
  );

  risa_cycle_counter u_run (
    .clk  (clk),
    .rstn (rstn),
    .clr  (run_clr),
    .en   (r.state == ST_RUN),
    .cnt  (run_cnt)
  );

  assign new_cmd   = bus.kernel_command_new;
  assign cmd       = bus.kernel_command;
  assign acc_run   = new_cmd && cmd == CMD_RUN &&
                     (r.state == ST_IDLE ||
                      r.state == ST_DONE);
  assign acc_halt  = new_cmd && cmd == CMD_HALT &&
                     r.state == ST_RUN;
  assign acc_abort = new_cmd && cmd == CMD_ABORT;
  assign acc_snap  = new_cmd && cmd == CMD_SNAP;
  assign bad       = new_cmd && !(acc_run || acc_halt ||
                     acc_abort || acc_snap);
  assign run_clr   = acc_run;

  always_comb begin
    r_d = r;
    unique case (r.state)
      ST_BOOT: begin
        if (r.hold_cnt == HW'(1)) begin
          r_d.state = ST_RUN;
          r_d.rst_n = 1'b1;
        end else begin
          r_d.hold_cnt = r.hold_cnt - HW'(1);
        end
      end
      ST_HALTING: begin
        // ack wins over a timeout landing on the same cycle
        if (core_halt_ack_i) begin
          r_d.state    = ST_DONE;
          r_d.rst_n    = 1'b0;
          r_d.halt_req = 1'b0;
          r_d.timeout  = 1'b0;
        end else if (r.tmo_cnt == TW'(HALT_TIMEOUT - 1)) begin
          r_d.state    = ST_DONE;
          r_d.rst_n    = 1'b0;
          r_d.halt_req = 1'b0;
          r_d.timeout  = 1'b1;
        end else begin
          r_d.tmo_cnt = r.tmo_cnt + TW'(1);
        end
      end
      default: ;
    endcase

    unique case (1'b1)
      acc_abort: begin
        r_d.state    = ST_IDLE;
        r_d.rst_n    = 1'b0;
        r_d.halt_req = 1'b0;
        r_d.timeout  = 1'b0;
        r_d.illegal  = 1'b0;
      end
      acc_run: begin
        r_d.state     = ST_BOOT;
        r_d.rst_n     = 1'b0;
        r_d.hold_cnt  = HW'(RST_HOLD);
        r_d.boot_addr = bus.kernel_engine_arg[WORD_W +: 32];
      end
      acc_halt: begin
        r_d.state    = ST_HALTING;
        r_d.halt_req = 1'b1;
        r_d.tmo_cnt  = '0;
      end
      acc_snap: begin
        r_d.snap_cyc = cyc_cnt;
        r_d.snap_run = run_cnt;
      end
      bad: begin
        r_d.illegal = 1'b1;
        if (r.err_cnt != '1)
          r_d.err_cnt = r.err_cnt + 32'd1;
      end
      default: ;
    endcase

    if (new_cmd && !bad) begin
      r_d.last_cmd = cmd;
      r_d.cmd_cnt  = r.cmd_cnt + 16'd1;
    end
  end

  always_comb begin
    st0         = '0;
    st0.timeout = r.timeout;
    st0.illegal = r.illegal;
    st0.state   = r.state;
    status_d    = '0;
    status_d[STATUS_IDX_CTRL*WORD_W +: WORD_W] =
      WORD_W'(st0);
    status_d[STATUS_IDX_CMD*WORD_W +: WORD_W] =
      WORD_W'({r.cmd_cnt, 8'h00, r.last_cmd});
    status_d[STATUS_IDX_SCYC_LO*WORD_W +: WORD_W] =
      WORD_W'(r.snap_cyc[31:0]);
    status_d[STATUS_IDX_SCYC_HI*WORD_W +: WORD_W] =
      WORD_W'(r.snap_cyc[63:32]);
    status_d[STATUS_IDX_SRUN_LO*WORD_W +: WORD_W] =
      WORD_W'(r.snap_run[31:0]);
    status_d[STATUS_IDX_SRUN_HI*WORD_W +: WORD_W] =
      WORD_W'(r.snap_run[63:32]);
    status_d[STATUS_IDX_BOOT*WORD_W +: WORD_W] =
      WORD_W'(r.boot_addr);
    status_d[STATUS_IDX_ERR*WORD_W +: WORD_W] =
      WORD_W'(r.err_cnt);
    status_d[STATUS_IDX_LCYC_LO*WORD_W +: WORD_W] =
      WORD_W'(cyc_cnt[31:0]);
    status_d[STATUS_IDX_LCYC_HI*WORD_W +: WORD_W] =
      WORD_W'(cyc_cnt[63:32]);
    status_d[STATUS_IDX_LRUN_LO*WORD_W +: WORD_W] =
      WORD_W'(run_cnt[31:0]);
    status_d[STATUS_IDX_LRUN_HI*WORD_W +: WORD_W] =
      WORD_W'(run_cnt[63:32]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r        <= '0;
      status_q <= '0;
    end else begin
      r        <= r_d;
      status_q <= status_d;
    end
  end

  assign bus.kernel_engine_status = status_q;
  assign core_rst_no      = r.rst_n;
  assign core_halt_req_o  = r.halt_req;
  assign core_boot_addr_o = {32'b0, r.boot_addr};
endmodule

// File: tb/tb_risa_kernel_ctrl.sv
// Directed bench for risa_kernel_ctrl: boot/halt
// sequencing, command legality table, counters.
module tb_risa_kernel_ctrl;
  import risa_kernel_ctrl_pkg::*;

  localparam int AN = 16;
  localparam int WW = 32;
  localparam int RH = 16;
  localparam int HT = 1024;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        core_halt_ack_i = 1'b0;
  logic        core_rst_no;
  logic        core_halt_req_o;
  logic [63:0] core_boot_addr_o;

  int checks = 0;
  int errors = 0;
  int k;

  risa_kernel_ctrl_if #(.ARG_NUM(AN), .WORD_W(WW)) bus ();

  risa_kernel_ctrl #(
    .ARG_NUM(AN), .WORD_W(WW),
    .RST_HOLD(RH), .HALT_TIMEOUT(HT)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .bus              (bus),
    .core_halt_ack_i  (core_halt_ack_i),
    .core_rst_no      (core_rst_no),
    .core_halt_req_o  (core_halt_req_o),
    .core_boot_addr_o (core_boot_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s7;
    string       name;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [31:0] sw(input int i);
    return bus.kernel_engine_status[i*WW +: WW];
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.kernel_command     = b;
    bus.kernel_command_new = 1'b1;
    @(negedge clk);
    bus.kernel_command_new = 1'b0;
    bus.kernel_command     = 8'h00;
  endtask

  task automatic wait_rst_high(output int n);
    n = 0;
    while (core_rst_no !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_rst_no"}, 64'(core_rst_no), 64'd0);
    chk({tag, "_halt"}, 64'(core_halt_req_o), 64'd0);
    chk({tag, "_boot"}, core_boot_addr_o, 64'd0);
    for (int i = 0; i < AN; i++)
      chk($sformatf("%s_st%0d", tag, i),
          64'(sw(i)), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{CMD_ABORT, 32'h00, 32'h0005_0003, 32'd0, "abort0"};
    tbl[1] = '{CMD_HALT,  32'h40, 32'h0005_0003, 32'd1, "halt_idle"};
    tbl[2] = '{8'h7E,     32'h40, 32'h0005_0003, 32'd2, "bad_7e"};
    tbl[3] = '{CMD_ABORT, 32'h00, 32'h0006_0003, 32'd2, "abort1"};
    tbl[4] = '{CMD_SNAP,  32'h00, 32'h0007_0004, 32'd2, "snap"};
    tbl[5] = '{8'h00,     32'h40, 32'h0007_0004, 32'd3, "bad_00"};
    tbl[6] = '{CMD_ABORT, 32'h00, 32'h0008_0003, 32'd3, "abort2"};

    bus.kernel_command     = 8'h00;
    bus.kernel_command_new = 1'b0;
    bus.kernel_engine_arg  = '0;
    bus.counter_reset      = 1'b0;
    bus.counter_start      = 1'b0;

    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_reset("reset");

    // boot sequence
    bus.kernel_engine_arg[WW +: WW] = 32'h8000_0000;
    send(CMD_RUN);
    chk("boot_rst_low", 64'(core_rst_no), 64'd0);
    wait_rst_high(k);
    chk("boot_hold_len", 64'(k), 64'(RH));
    chk("boot_addr_o", core_boot_addr_o, 64'h8000_0000);
    repeat (10) @(negedge clk);
    chk("run_state", 64'(sw(0)), 64'h2);
    chk("run_boot_word", 64'(sw(6)), 64'h8000_0000);
    chk("run_cnt_lo", 64'(sw(10)), 64'd9);
    chk("run_cnt_hi", 64'(sw(11)), 64'd0);

    // halt with ack on cycle 5
    send(CMD_HALT);
    chk("halt_req_on", 64'(core_halt_req_o), 64'd1);
    chk("halt_core_live", 64'(core_rst_no), 64'd1);
    repeat (5) @(negedge clk);
    core_halt_ack_i = 1'b1;
    @(negedge clk);
    core_halt_ack_i = 1'b0;
    chk("ack_rst_no", 64'(core_rst_no), 64'd0);
    chk("ack_halt_off", 64'(core_halt_req_o), 64'd0);
    @(negedge clk);
    chk("ack_status", 64'(sw(0)), 64'h04);

    // rerun from DONE, then halt without ack
    send(CMD_RUN);
    wait_rst_high(k);
    chk("reboot_hold_len", 64'(k), 64'(RH));
    send(CMD_HALT);
    k = 0;
    while (core_halt_req_o === 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_len", 64'(k), 64'(HT));
    chk("tmo_rst_no", 64'(core_rst_no), 64'd0);
    @(negedge clk);
    chk("tmo_status", 64'(sw(0)), 64'h84);
    chk("tmo_cmd_word", 64'(sw(1)), 64'h0004_0002);

    // command legality table
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].cmd);
      @(negedge clk);
      chk({tbl[i].name, "_s0"}, 64'(sw(0)), 64'(tbl[i].s0));
      chk({tbl[i].name, "_s1"}, 64'(sw(1)), 64'(tbl[i].s1));
      chk({tbl[i].name, "_s7"}, 64'(sw(7)), 64'(tbl[i].s7));
    end

    // free-running counter, 100 enabled cycles
    @(negedge clk);
    bus.counter_start = 1'b1;
    repeat (100) @(negedge clk);
    bus.counter_start = 1'b0;
    send(CMD_SNAP);
    @(negedge clk);
    chk("snap_cyc_lo", 64'(sw(2)), 64'd100);
    chk("snap_cyc_hi", 64'(sw(3)), 64'd0);
    chk("live_cyc_lo", 64'(sw(8)), 64'd100);

    // clear beats start
    bus.counter_reset = 1'b1;
    bus.counter_start = 1'b1;
    repeat (2) @(negedge clk);
    bus.counter_reset = 1'b0;
    bus.counter_start = 1'b0;
    @(negedge clk);
    chk("clr_cyc_lo", 64'(sw(8)), 64'd0);
    chk("clr_cyc_hi", 64'(sw(9)), 64'd0);

    // carry across the 32-bit boundary
    @(negedge clk);
    force dut.u_cyc.cnt = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    release dut.u_cyc.cnt;
    bus.counter_start = 1'b1;
    repeat (4) @(negedge clk);
    bus.counter_start = 1'b0;
    send(CMD_SNAP);
    @(negedge clk);
    chk("snap_carry", {sw(3), sw(2)}, 64'h1_0000_0002);

    // async reset in the middle of BOOT
    send(CMD_RUN);
    repeat (3) @(negedge clk);
    chk("pre_rst_boot", 64'(sw(0)), 64'h1);
    rstn = 1'b0;
    #1;
    chk_all_reset("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_rst_no", 64'(core_rst_no), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
